// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between instruction
// fetch (IF) and the MEM stage. Accesses of 1, 2 or 4 bytes are serialised
// little-endian. MEM wins contention, except that a pending IF request gets
// the port right after a MEM access. A taken jump (if_flush) aborts an
// in-flight fetch without a done pulse.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_width,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;             // edges since grant, minus one
  logic [2:0]        len_q, len_d;             // access length in bytes
  logic              owner_mem_q, owner_mem_d; // last/current grant, 1 = MEM
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [2:0]        step;       // index of the edge being computed, relative to the grant edge
  logic [ADDR_W-1:0] step_addr;
  logic [2:0]        mem_len;
  logic              grant_mem;
  logic              grant_if;
  logic [7:0]        wbyte;
  logic [31:0]       rbuf_next;

  assign step      = cnt_q + 3'd1;
  assign step_addr = base_q + ADDR_W'(step);
  assign mem_len   = (mem_width == 4'd1) ? 3'd1 : (mem_width == 4'd2) ? 3'd2 : 3'd4;
  // MEM wins unless it also had the previous grant and a live IF request waits.
  assign grant_mem = mem_req && !(owner_mem_q && if_req && !if_flush);
  assign grant_if  = if_req && !if_flush;

  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;

  // Select the store byte that goes out on this edge.
  always_comb begin
    case (step[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Read assembly: ram_din holds the byte addressed two edges ago (index step-2).
  always_comb begin
    rbuf_next = rbuf_q;
    for (int k = 0; k < 4; k++) begin
      if (int'(step) - 2 == k) rbuf_next[8*k +: 8] = ram_din;
    end
  end

  // Next-state, arbitration and RAM/requester output logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, which rules out latches.
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    owner_mem_d = owner_mem_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          owner_mem_d = 1'b1;
          base_d      = mem_addr;
          len_d       = mem_len;
          wdata_d     = mem_wdata;
          cnt_d       = 3'd0;
          rbuf_d      = '0;
          ram_addr_d  = mem_addr;
          if (mem_wr) begin
            state_d    = WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end else if (grant_if) begin
          owner_mem_d = 1'b0;
          base_d      = if_addr;
          len_d       = 3'd4;
          cnt_d       = 3'd0;
          rbuf_d      = '0;
          ram_addr_d  = if_addr;
          state_d     = READ;
        end
      end

      READ: begin
        if (!owner_mem_q && if_flush) begin
          // Misprediction: drop the fetch, in-flight bytes are ignored.
          state_d    = IDLE;
          ram_addr_d = '0;
        end else begin
          cnt_d  = step;
          rbuf_d = rbuf_next;
          if (step < len_q) ram_addr_d = step_addr;
          if (step == len_q + 3'd1) begin
            state_d = TURN;
            if (owner_mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rbuf_next;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rbuf_next;
            end
          end
        end
      end

      WRITE: begin
        cnt_d = step;
        if (step < len_q) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = step_addr;
          ram_dout_d = wbyte;
        end else begin
          mem_done_d = 1'b1;
          state_d    = TURN;
        end
      end

      default: begin
        // TURN: one dead cycle so the finished requester can drop its request.
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves last grant = IF and every output low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      owner_mem_q <= owner_mem_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte RAM with one-cycle read latency, a
// transaction-level model predicting every cycle's outputs from the grant
// rules and per-access cycle offsets, and directed scenarios with literal
// expectations for latency, data and flush/reset behaviour.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_flush, mem_req, mem_wr;
  logic [ADDR_W-1:0] if_addr, mem_addr;
  logic [3:0]        mem_width;
  logic [31:0]       mem_wdata;
  logic              if_done, mem_done, ram_wr;
  logic [31:0]       if_data, mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_width(mem_width), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM environment and its shadow copy ----------------
  logic [7:0] ram_m [logic [31:0]];
  logic [7:0] sh_m  [logic [31:0]];

  function automatic logic [7:0] ram_init(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_get(input logic [31:0] a);
    if (ram_m.exists(a)) return ram_m[a];
    return ram_init(a);
  endfunction

  function automatic logic [7:0] sh_get(input logic [31:0] a);
    if (sh_m.exists(a)) return sh_m[a];
    return ram_init(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram_m[a] = v;
    sh_m[a]  = v;
  endtask

  // Synchronous RAM: address sampled at an edge, data valid after it.
  initial forever begin
    @(posedge clk);
    ram_din <= ram_get(ram_addr);
    if (ram_wr) ram_m[ram_addr] = ram_dout;
  end

  // ---------------- transaction-level reference model ----------------
  int          cyc;
  bit          m_busy, m_is_mem, m_wr, m_last_mem;
  int          m_start, m_len, m_next_ok;
  logic [31:0] m_addr, m_wdata;
  bit          e_if_done, e_mem_done, e_ram_wr, e_addr_chk, e_data_chk;
  logic [31:0] e_addr, e_data;
  logic [7:0]  e_dout;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  function automatic int width_bytes(input logic [3:0] w);
    if (w == 4'd1) return 1;
    if (w == 4'd2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] le_read(input logic [31:0] a, input int n);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[8*k +: 8] = sh_get(a + 32'(k));
    return d;
  endfunction

  task automatic model_start(input bit is_mem, input bit wr, input logic [31:0] a,
                             input int n, input logic [31:0] wd);
    m_busy = 1; m_start = cyc; m_is_mem = is_mem; m_last_mem = is_mem;
    m_wr = wr; m_addr = a; m_len = n; m_wdata = wd;
    e_addr_chk = 1; e_addr = a;
    if (wr) begin
      e_ram_wr = 1;
      e_dout   = byte_of(wd, 0);
    end
  endtask

  task automatic model_step();
    int t;
    e_if_done = 0; e_mem_done = 0; e_ram_wr = 0; e_addr_chk = 0; e_data_chk = 0;
    if (rst) begin
      cyc = 0; m_busy = 0; m_next_ok = 0; m_last_mem = 0;
      return;
    end
    cyc++;
    if (m_busy) begin
      t = cyc - m_start;
      // The RAM commits a store byte one edge after it is presented.
      if (m_wr && t >= 1 && t <= m_len) sh_m[m_addr + 32'(t - 1)] = byte_of(m_wdata, t - 1);
      if (!m_is_mem && if_flush) begin
        m_busy = 0; e_addr_chk = 1; e_addr = '0; m_next_ok = cyc + 1;
      end else if (m_wr) begin
        if (t < m_len) begin
          e_ram_wr = 1; e_addr_chk = 1; e_addr = m_addr + 32'(t); e_dout = byte_of(m_wdata, t);
        end else begin
          e_mem_done = 1; m_busy = 0; m_next_ok = cyc + 2;
        end
      end else begin
        if (t < m_len) begin
          e_addr_chk = 1; e_addr = m_addr + 32'(t);
        end else if (t == m_len + 1) begin
          e_data = le_read(m_addr, m_len); e_data_chk = 1;
          if (m_is_mem) e_mem_done = 1; else e_if_done = 1;
          m_busy = 0; m_next_ok = cyc + 2;
        end
      end
    end else if (cyc >= m_next_ok) begin
      if (mem_req && !(m_last_mem && if_req && !if_flush))
        model_start(1, mem_wr, mem_addr, width_bytes(mem_width), mem_wdata);
      else if (if_req && !if_flush)
        model_start(0, 0, if_addr, 4, '0);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Compare process: DUT outputs against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_ctl", 64'({if_done, mem_done, ram_wr, ram_dout}), 64'h0);
      check("rst_addr", 64'(ram_addr), 64'h0);
      check("rst_data", {if_data, mem_rdata}, 64'h0);
    end else begin
      check("if_done", 64'(if_done), 64'(e_if_done));
      check("mem_done", 64'(mem_done), 64'(e_mem_done));
      check("ram_wr", 64'(ram_wr), 64'(e_ram_wr));
      if (e_ram_wr) check("ram_dout", 64'(ram_dout), 64'(e_dout));
      if (e_addr_chk) check("ram_addr", 64'(ram_addr), 64'(e_addr));
      if (e_if_done) check("if_data", 64'(if_data), 64'(e_data));
      if (e_mem_done && e_data_chk) check("mem_rdata", 64'(mem_rdata), 64'(e_data));
    end
  end

  // ---------------- requester helpers ----------------
  task automatic wait_mem(input int budget, output int at, output logic [31:0] d, output int wrc);
    at = -1; d = '0; wrc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ram_wr) wrc++;
      if (mem_done) begin
        at = cyc; d = mem_rdata;
        break;
      end
    end
  endtask

  task automatic wait_if(input int budget, output int at, output logic [31:0] d);
    at = -1; d = '0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (if_done) begin
        at = cyc; d = if_data;
        break;
      end
    end
  endtask

  // One MEM access from IDLE; lat counts edges from request to done.
  task automatic mem_access(input logic wr, input logic [31:0] a, input logic [3:0] w,
                            input logic [31:0] wd, output int lat, output logic [31:0] rd,
                            output int wrc);
    int start, at;
    mem_wr = wr; mem_addr = a; mem_width = w; mem_wdata = wd; mem_req = 1'b1;
    start = cyc;
    wait_mem(40, at, rd, wrc);
    mem_req = 1'b0;
    lat = (at < 0) ? -1 : at - start;
    @(posedge clk); #1;
  endtask

  // ---------------- directed scenarios ----------------
  int          c_mem1, c_if, c_mem2, lat, wrc, early, start, at, dummy;
  logic [31:0] d_mem1, d_if, d_mem2, rd;

  initial begin
    rst = 1'b1;
    if_req = 0; if_flush = 0; if_addr = '0;
    mem_req = 0; mem_wr = 0; mem_addr = '0; mem_width = 4'd4; mem_wdata = '0;
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h7, 8'h80);
    preload(32'h301, 8'h77);
    preload(32'h2000, 8'h01); preload(32'h2001, 8'h23);
    preload(32'h2002, 8'h45); preload(32'h2003, 8'h67);

    // Contention from reset: MEM load, then IF, then MEM store.
    if_req = 1; if_addr = 32'h3000;
    mem_req = 1; mem_wr = 0; mem_addr = 32'h100; mem_width = 4'd4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fork
      begin
        wait_mem(40, c_mem1, d_mem1, dummy);
        mem_req = 0;
        @(posedge clk); #1;
        mem_wr = 1; mem_addr = 32'h500; mem_width = 4'd1; mem_wdata = 32'h0000005A; mem_req = 1;
        wait_mem(60, c_mem2, d_mem2, dummy);
        mem_req = 0;
      end
      begin
        wait_if(60, c_if, d_if);
        if_req = 0;
      end
    join
    check("cont_mem1_cycle", 64'(c_mem1), 64'd6);
    check("cont_mem1_data", 64'(d_mem1), 64'h44332211);
    check("cont_if_cycle", 64'(c_if), 64'd13);
    check("cont_mem2_cycle", 64'(c_mem2), 64'd16);
    @(posedge clk); #1;

    // Store half across a 0x2FF/0x300 boundary.
    mem_access(1, 32'h2FF, 4'd2, 32'hAABBCCDD, lat, rd, wrc);
    check("sh_lat", 64'(lat), 64'd3);
    check("sh_wr_cycles", 64'(wrc), 64'd2);
    check("sh_ram_2ff", 64'(ram_get(32'h2FF)), 64'hDD);
    check("sh_ram_300", 64'(ram_get(32'h300)), 64'hCC);
    check("sh_ram_301", 64'(ram_get(32'h301)), 64'h77);

    // Byte load, zero-extended.
    mem_access(0, 32'h7, 4'd1, '0, lat, rd, wrc);
    check("lb_lat", 64'(lat), 64'd3);
    check("lb_data", 64'(rd), 64'h00000080);

    // Illegal width 3 behaves as a word.
    mem_access(0, 32'h100, 4'd3, '0, lat, rd, wrc);
    check("lw3_lat", 64'(lat), 64'd6);
    check("lw3_data", 64'(rd), 64'h44332211);

    // Half load wrapping the top of the address space.
    mem_access(0, 32'hFFFFFFFF, 4'd2, '0, lat, rd, wrc);
    check("wrap_lat", 64'(lat), 64'd4);
    check("wrap_data", 64'(rd), 64'h00005A5A);

    // Flush an IF read at E0+2, then refetch from 0x2000.
    early = 0;
    if_addr = 32'h1000; if_req = 1;
    start = cyc;
    repeat (3) begin
      @(posedge clk); #1;
      if (if_done) early++;
    end
    if_flush = 1; if_addr = 32'h2000;
    @(posedge clk); #1;
    if (if_done) early++;
    check("flush_ram_addr", 64'(ram_addr), 64'h0);
    if_flush = 0;
    wait_if(40, at, rd);
    if_req = 0;
    check("flush_no_done", 64'(early), 64'd0);
    check("flush_refetch_lat", 64'((at < 0) ? -1 : at - start), 64'd10);
    check("flush_refetch_data", 64'(rd), 64'h67452301);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a word store.
    mem_wr = 1; mem_addr = 32'h400; mem_width = 4'd4; mem_wdata = 32'h01020304; mem_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("prerst_wr", 64'(ram_wr), 64'd1);
    check("prerst_addr", 64'(ram_addr), 64'h401);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wr", 64'(ram_wr), 64'd0);
    check("rst_async_addr", 64'(ram_addr), 64'h0);
    mem_req = 0;
    early = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_done) early++;
    end
    rst = 1'b0;
    check("rst_no_done", 64'(early), 64'd0);
    mem_access(1, 32'h400, 4'd4, 32'hCAFEF00D, lat, rd, wrc);
    check("post_rst_st_lat", 64'(lat), 64'd5);
    check("post_rst_st_wr_cycles", 64'(wrc), 64'd4);
    check("post_rst_ram_403", 64'(ram_get(32'h403)), 64'hCA);
    mem_access(0, 32'h400, 4'd4, '0, lat, rd, wrc);
    check("post_rst_ld_lat", 64'(lat), 64'd6);
    check("post_rst_ld_data", 64'(rd), 64'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
